// File: rtl/light_arbiter.sv
// -----------------------------------------------------------------------------
// light_arbiter
//   Shared-lamp controller. NUM_BUTTONS raw wall buttons are debounced. Each
//   accepted press is latched as a pending request. Pending requests are
//   granted round-robin, one per cycle. Each grant drives a lamp sequencer
//   with the states OFF, ON and WARN. In ON and WARN, a timer turns the lamp
//   off automatically if no further grant arrives.
//
// Ports
//   clk     in   1            rising-edge clock
//   reset   in   1            synchronous, active-high; clears all state
//   button  in   NUM_BUTTONS  raw button levels, 1 = pressed
//   light   out  1            lamp drive, high in ON and WARN
//   warn    out  1            high only in WARN (auto-off is imminent)
//   grant   out  NUM_BUTTONS  registered one-hot pulse: press i was serviced
// -----------------------------------------------------------------------------
module light_arbiter #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ON_CYCLES       = 20,
  parameter int WARN_CYCLES     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic                   light,
  output logic                   warn,
  output logic [NUM_BUTTONS-1:0] grant
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RR_W  = $clog2(NUM_BUTTONS);
  localparam int T_MAX = (ON_CYCLES > WARN_CYCLES) ? ON_CYCLES : WARN_CYCLES;
  localparam int T_W   = $clog2(T_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [T_W-1:0]   ON_LAST   = T_W'(ON_CYCLES - 1);
  localparam logic [T_W-1:0]   WARN_LAST = T_W'(WARN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_WARN = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [T_W-1:0]           timer, timer_next;
  logic [NUM_BUTTONS-1:0]   db_state, db_state_next;
  logic [CNT_W-1:0]         db_cnt      [NUM_BUTTONS];
  logic [CNT_W-1:0]         db_cnt_next [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0]   rise;
  logic [NUM_BUTTONS-1:0]   pending, pending_next;
  logic [NUM_BUTTONS-1:0]   grant_next;
  logic [RR_W-1:0]          rr, rr_next;
  logic                     granted;

  // Debounce: a new level is accepted on the DEBOUNCE_CYCLES-th consecutive
  // sample that differs from the accepted level. Any agreeing sample restarts
  // the run. Only an accepted 0->1 transition counts as a press.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    db_state_next = db_state;
    rise          = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_next[i] = '0;
      if (button[i] != db_state[i]) begin
        if (db_cnt[i] == CNT_LAST) begin
          db_state_next[i] = button[i];
          rise[i]          = button[i];
        end else begin
          db_cnt_next[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin pick: the first pending bit scanning from rr upward, mod N.
  always_comb begin : arb
    int idx;
    idx        = 0;
    grant_next = '0;
    rr_next    = rr;
    granted    = 1'b0;
    for (int j = 0; j < NUM_BUTTONS; j++) begin
      idx = (int'(rr) + j) % NUM_BUTTONS;
      if (!granted && pending[idx]) begin
        granted         = 1'b1;
        grant_next[idx] = 1'b1;
        rr_next         = (idx == NUM_BUTTONS - 1) ? '0 : RR_W'(idx + 1);
      end
    end
  end

  // A press arriving on the same edge as a grant of that bit stays pending.
  // Only its own grant clears it.
  assign pending_next = (pending & ~grant_next) | rise;

  // The lamp sequencer reacts to the grant on the same edge it is issued.
  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      ST_OFF: begin
        if (granted) begin
          state_next = ST_ON;
          timer_next = '0;
        end
      end
      ST_ON: begin
        if (granted) begin
          state_next = ST_OFF;
          timer_next = '0;
        end else if (timer == ON_LAST) begin
          state_next = ST_WARN;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_WARN: begin
        if (granted) begin
          state_next = ST_ON;      // re-arm; the lamp stays lit
          timer_next = '0;
        end else if (timer == WARN_LAST) begin
          state_next = ST_OFF;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: begin
        state_next = ST_OFF;
        timer_next = '0;
      end
    endcase
  end

  // NOTE: register updates use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_OFF;
      timer    <= '0;
      rr       <= '0;
      pending  <= '0;
      db_state <= '0;
      grant    <= '0;
      // NOTE: the debounce counter array is cleared explicitly, because a stale count would make a held button accept early after reset.
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      rr       <= rr_next;
      pending  <= pending_next;
      db_state <= db_state_next;
      grant    <= grant_next;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= db_cnt_next[i];
    end
  end

  assign light = (state != ST_OFF);
  assign warn  = (state == ST_WARN);

endmodule

// File: tb/tb_light_arbiter.sv
// -----------------------------------------------------------------------------
// tb_light_arbiter
//   Self-checking bench for light_arbiter (N=4, D=4, ON=20, WARN=8).
//   A behavioural model steps on every rising edge. It tracks stable button
//   levels with run lengths, a pending-request vector and a round-robin
//   pointer. It models the lamp as lit/warning flags plus a countdown of the
//   cycles left in the current phase. On every falling edge, the DUT outputs
//   are compared against the model. Directed scenarios also check
//   hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_light_arbiter;

  localparam int N      = 4;
  localparam int D      = 4;
  localparam int ON_C   = 20;
  localparam int WARN_C = 8;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic [N-1:0] button = '0;
  logic         light;
  logic         warn;
  logic [N-1:0] grant;

  always #5 clk = ~clk;

  light_arbiter #(
    .NUM_BUTTONS    (N),
    .DEBOUNCE_CYCLES(D),
    .ON_CYCLES      (ON_C),
    .WARN_CYCLES    (WARN_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .light (light),
    .warn  (warn),
    .grant (grant)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_run [N];   // consecutive samples that differ from the stable level
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_grant = '0;
  int           m_rr    = 0;
  bit           m_lit   = 1'b0;
  bit           m_warn  = 1'b0;
  int           m_left  = 0;   // edges remaining in the current lit phase

  task automatic model_step();
    int           k;
    logic [N-1:0] rise;
    if (reset) begin
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_level = '0; m_pend = '0; m_grant = '0; m_rr = 0;
      m_lit = 1'b0; m_warn = 1'b0; m_left = 0;
      return;
    end
    k = -1;
    for (int j = 0; j < N; j++)
      if (k < 0 && m_pend[(m_rr + j) % N]) k = (m_rr + j) % N;
    rise = '0;
    for (int i = 0; i < N; i++) begin
      if (button[i] == m_level[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_level[i] = button[i];
          m_run[i]   = 0;
          rise[i]    = button[i];
        end
      end
    end
    m_grant = '0;
    if (k >= 0) begin
      m_grant[k] = 1'b1;
      m_pend[k]  = 1'b0;
      m_rr       = (k + 1) % N;
    end
    m_pend = m_pend | rise;
    if (k >= 0) begin
      if (!m_lit) begin m_lit = 1'b1; m_warn = 1'b0; m_left = ON_C; end
      else if (m_warn) begin m_warn = 1'b0; m_left = ON_C; end
      else begin m_lit = 1'b0; m_left = 0; end
    end else if (m_lit) begin
      m_left--;
      if (m_left == 0) begin
        if (!m_warn) begin m_warn = 1'b1; m_left = WARN_C; end
        else begin m_lit = 1'b0; m_warn = 1'b0; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_grant", 32'(grant), 32'(m_grant));
      check("model_light", 32'(light), 32'(m_lit));
      check("model_warn",  32'(warn),  32'(m_warn));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    int rate;

    reset  = 1'b1;
    button = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    reset  = 1'b0;

    // 1. idle after reset
    repeat (10) begin
      @(negedge clk);
      check("s1_idle", 32'({light, warn, grant}), 32'h0);
    end

    // 2. single press: pending after 4 edges, grant and light on the 5th
    button = 4'b0010;
    repeat (4) @(negedge clk);
    check("s2_no_grant_yet", 32'(grant), 32'h0);
    @(negedge clk);
    check("s2_grant", 32'(grant), 32'h2);
    check("s2_light_on", 32'(light), 32'h1);
    button = '0;
    repeat (6) @(negedge clk);
    button = 4'b0010;
    repeat (5) @(negedge clk);
    check("s2_second_grant", 32'(grant), 32'h2);
    check("s2_light_off", 32'(light), 32'h0);
    button = '0;
    repeat (6) @(negedge clk);

    // 3. short glitches are rejected
    for (int len = 1; len <= 3; len++) begin
      button = 4'b0001;
      repeat (len) begin
        @(negedge clk);
        check("s3_glitch", 32'({light, grant}), 32'h0);
      end
      button = '0;
      repeat (4) begin
        @(negedge clk);
        check("s3_glitch", 32'({light, grant}), 32'h0);
      end
    end

    // 4. simultaneous presses 0,2,3 from rr=0
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    button = 4'b1101;
    repeat (4) @(negedge clk);
    check("s4_no_grant_yet", 32'(grant), 32'h0);
    @(negedge clk);
    check("s4_grant0", 32'({grant, light}), 32'({4'b0001, 1'b1}));
    @(negedge clk);
    check("s4_grant2", 32'({grant, light}), 32'({4'b0100, 1'b0}));
    @(negedge clk);
    check("s4_grant3", 32'({grant, light}), 32'({4'b1000, 1'b1}));
    button = '0;
    repeat (6) @(negedge clk);
    button = 4'b0011;            // rr back at 0: button 0 must win first
    repeat (5) @(negedge clk);
    check("s4_rr_wrapped", 32'(grant), 32'h1);
    @(negedge clk);
    check("s4_rr_next", 32'(grant), 32'h2);
    button = '0;
    repeat (6) @(negedge clk);

    // 5. auto-off timing and re-arm during WARN
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    button = 4'b0100;
    repeat (5) @(negedge clk);
    button = '0;
    for (int i = 0; i < ON_C; i++) begin
      if (i > 0) @(negedge clk);
      check("s5_on_phase", 32'({light, warn}), 32'h2);
    end
    for (int i = 0; i < WARN_C; i++) begin
      @(negedge clk);
      check("s5_warn_phase", 32'({light, warn}), 32'h3);
    end
    @(negedge clk);
    check("s5_auto_off", 32'({light, warn}), 32'h0);

    button = 4'b0100;
    repeat (5) @(negedge clk);
    button = '0;
    found  = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (warn) found = 1'b1;
    end
    check("s5_warn_reached", 32'(found), 32'h1);
    button = 4'b0100;
    repeat (5) @(negedge clk);
    button = '0;
    check("s5_rearm", 32'({grant, light, warn}), 32'({4'b0100, 2'b10}));
    for (int i = 1; i < ON_C; i++) begin
      @(negedge clk);
      check("s5_rearm_on", 32'({light, warn}), 32'h2);
    end
    @(negedge clk);
    check("s5_rearm_warn", 32'({light, warn}), 32'h3);

    // 6. reset in WARN with pending[3]
    button = 4'b1000;
    repeat (4) @(negedge clk);
    reset  = 1'b1;
    button = '0;
    @(negedge clk);
    reset = 1'b0;
    check("s6_after_reset", 32'({light, warn, grant}), 32'h0);
    repeat (10) begin
      @(negedge clk);
      check("s6_no_late_grant", 32'({light, grant}), 32'h0);
    end

    // 7. randomized traffic at several press rates, occasional resets
    for (int blk = 0; blk < 6; blk++) begin
      case (blk % 3)
        0:       rate = 4;
        1:       rate = 12;
        default: rate = 60;
      endcase
      repeat (500) begin
        @(negedge clk);
        reset = ($urandom_range(0, 399) == 0);
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, rate - 1) == 0) button[i] = ~button[i];
      end
    end
    reset  = 1'b0;
    button = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
